// File: rtl/alu_pkg.sv
// Shared definitions for the alu_arb slice: operand/result widths, op codes
// and FSM state encoding.
package alu_pkg;

    localparam int DW = 6;
    localparam int RW = 12;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for alu_arb: add/sub/mult, and div when ALU_ARB_DIV_EN is
// defined (otherwise div reports an error with a zero result).
module alu_core
    import alu_pkg::*;
(
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    input  logic        [1:0]    op_i,
    output logic        [RW-1:0] data_o,
    output logic                 err_o
);

    logic signed [DW-1:0] sum;
    logic signed [DW-1:0] diff;
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] prod;

    always_comb begin
        a_ext = {{(RW-DW){a_i[DW-1]}}, a_i};
        b_ext = {{(RW-DW){b_i[DW-1]}}, b_i};
        sum   = a_i + b_i;
        diff  = a_i - b_i;
        prod  = a_ext * b_ext;
    end

`ifdef ALU_ARB_DIV_EN
    // One extra bit so -32 / -1 does not trap; the quotient wraps to 6 bits.
    logic signed [DW:0]   a_w;
    logic signed [DW:0]   b_w;
    logic signed [DW-1:0] quot;
    logic signed [DW-1:0] rem;

    always_comb begin
        a_w  = {a_i[DW-1], a_i};
        b_w  = {b_i[DW-1], b_i};
        quot = '0;
        rem  = '0;
        if (b_i != '0) begin
            quot = DW'(a_w / b_w);
            rem  = DW'(a_w % b_w);
        end
    end
`endif

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (op_i)
            OP_ADD: data_o = {{(RW-DW){1'b0}}, sum};
            OP_SUB: data_o = {{(RW-DW){1'b0}}, diff};
            OP_MUL: data_o = prod;
            default: begin
`ifdef ALU_ARB_DIV_EN
                if (b_i == '0) begin
                    data_o = {RW{1'b1}};
                    err_o  = 1'b1;
                end else begin
                    data_o = {rem, quot};
                end
`else
                data_o = '0;
                err_o  = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of a shared multi-cycle ALU.
// Divider present only when ALU_ARB_DIV_EN is defined.
module alu_arb
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req0_valid_i,
    input  logic          req1_valid_i,
    output logic          req0_ready_o,
    output logic          req1_ready_o,
    input  logic [DW-1:0] req0_A_i,
    input  logic [DW-1:0] req0_B_i,
    input  logic [DW-1:0] req1_A_i,
    input  logic [DW-1:0] req1_B_i,
    input  logic [1:0]    req0_Op_i,
    input  logic [1:0]    req1_Op_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [RW-1:0] rsp_data_o,
    output logic          rsp_id_o,
    output logic          rsp_err_o,
    output logic          busy_o
);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic rr_q, rr_d;

    logic signed [DW-1:0] a_q, a_d;
    logic signed [DW-1:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic id_q, id_d;

    logic gnt_vld;
    logic gnt_id;
    logic [1:0] gnt_op;
    logic [RW-1:0] core_data;
    logic core_err;

    function automatic logic [3:0] exec_lat(input logic [1:0] op);
        case (op)
            OP_MUL: return 4'(MUL_LAT);
`ifdef ALU_ARB_DIV_EN
            OP_DIV: return 4'(DIV_LAT);
`endif
            default: return 4'd1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        gnt_op  = req0_Op_i;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    gnt_vld = 1'b1;
                    gnt_id  = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
                    gnt_op  = gnt_id ? req1_Op_i : req0_Op_i;
                    state_d = ST_EXEC;
                    cnt_d   = exec_lat(gnt_op);
                    rr_d    = ~gnt_id;
                end
            end
            ST_EXEC: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands stay frozen from grant until the next grant, so the core
    // output is stable throughout RESP without a result register.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        id_d = id_q;
        if (gnt_vld) begin
            a_d  = gnt_id ? req1_A_i : req0_A_i;
            b_d  = gnt_id ? req1_B_i : req0_B_i;
            op_d = gnt_op;
            id_d = gnt_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
        id_q <= id_d;
    end

    alu_core u_core (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .data_o (core_data),
        .err_o  (core_err)
    );

    // Grant strobes are masked by reset so nothing is offered while held.
    assign req0_ready_o = rst_n_i & gnt_vld & ~gnt_id;
    assign req1_ready_o = rst_n_i & gnt_vld & gnt_id;
    assign busy_o       = (state_q != ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_data_o   = rsp_valid_o ? core_data : '0;
    assign rsp_id_o     = rsp_valid_o & id_q;
    assign rsp_err_o    = rsp_valid_o & core_err;

endmodule

// File: tb/tb_alu_arb.sv
// Randomized bench for alu_arb against a transaction-level model; honours
// ALU_ARB_DIV_EN in the same way as the design.
module tb_alu_arb;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic v0, v1, rsp_rdy;
    logic ready0, ready1;
    logic [5:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;
    logic rsp_valid, rsp_id, rsp_err, busy;
    logic [11:0] rsp_data;

    int n_chk = 0;
    int n_pass = 0;
    bit ptr = 1'b0;

    always #5 clk = ~clk;

    alu_arb #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req0_valid_i (v0),
        .req1_valid_i (v1),
        .req0_ready_o (ready0),
        .req1_ready_o (ready1),
        .req0_A_i     (a0),
        .req0_B_i     (b0),
        .req1_A_i     (a1),
        .req1_B_i     (b1),
        .req0_Op_i    (op0),
        .req1_Op_i    (op1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_rdy),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the signed operand values.
    task automatic model_op(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                            output logic [11:0] d, output logic e, output int lat);
        int ai, bi, r;
        ai = $signed(a);
        bi = $signed(b);
        e = 1'b0;
        lat = 1;
        d = '0;
        case (op)
            2'd0: begin r = ai + bi; d = {6'b0, 6'(r)}; end
            2'd1: begin r = ai - bi; d = {6'b0, 6'(r)}; end
            2'd2: begin r = ai * bi; d = 12'(r); lat = MUL_LAT; end
            default: begin
`ifdef ALU_ARB_DIV_EN
                lat = DIV_LAT;
                if (bi == 0) begin
                    d = 12'hFFF;
                    e = 1'b1;
                end else begin
                    d = {6'(ai % bi), 6'(ai / bi)};
                end
`else
                d = 12'h000;
                e = 1'b1;
`endif
            end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdy0"}, ready0, 0);
        chk({tag, "_rdy1"}, ready1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_vld"}, rsp_valid, 0);
        chk({tag, "_data"}, rsp_data, 0);
        chk({tag, "_id"}, rsp_id, 0);
        chk({tag, "_err"}, rsp_err, 0);
    endtask

    // Inputs are already driven with the DUT idle; the grant happens this cycle.
    task automatic do_txn(input bit keep_both, input int hold);
        logic w;
        logic [11:0] ed;
        logic ee;
        int lat;
        @(negedge clk);
        w = (v0 && v1) ? ptr : v1;
        if (w) model_op(a1, b1, op1, ed, ee, lat);
        else   model_op(a0, b0, op0, ed, ee, lat);
        chk("grant0", ready0, !w);
        chk("grant1", ready1, w);
        chk("grant_busy", busy, 0);
        chk("grant_vld", rsp_valid, 0);
        ptr = !w;
        @(posedge clk); #1;
        if (keep_both) begin
            if (w) begin a1 = 6'($urandom); b1 = 6'($urandom); op1 = 2'($urandom_range(0, 1)); end
            else   begin a0 = 6'($urandom); b0 = 6'($urandom); op0 = 2'($urandom_range(0, 1)); end
        end else begin
            v0 = 1'b0;
            v1 = 1'b0;
        end
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("exec_vld", rsp_valid, 0);
            chk("exec_busy", busy, 1);
            chk("exec_nogrant", ready0 | ready1, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k <= hold; k++) begin
            rsp_rdy = (k == hold);
            @(negedge clk);
            chk("rsp_vld", rsp_valid, 1);
            chk("rsp_data", rsp_data, ed);
            chk("rsp_id", rsp_id, w);
            chk("rsp_err", rsp_err, ee);
            chk("rsp_nogrant", ready0 | ready1, 0);
            @(posedge clk); #1;
        end
        rsp_rdy = 1'b1;
    endtask

    task automatic set_req(input int who, input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
        if (who == 0) begin v0 = 1'b1; v1 = 1'b0; a0 = a; b0 = b; op0 = op; end
        else          begin v1 = 1'b1; v0 = 1'b0; a1 = a; b1 = b; op1 = op; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1; rsp_rdy = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        ptr = 1'b0;

        // Directed vectors
        set_req(0, 6'd5, 6'h3D, 2'd0);  do_txn(0, 0);
        set_req(1, 6'h39, 6'd9, 2'd2);  do_txn(0, 0);
        set_req(0, 6'h33, 6'd4, 2'd3);  do_txn(0, 0);
        set_req(1, 6'h33, 6'd0, 2'd3);  do_txn(0, 0);
        set_req(0, 6'd31, 6'd1, 2'd0);  do_txn(0, 0);
        set_req(1, 6'h20, 6'h20, 2'd2); do_txn(0, 0);
        set_req(0, 6'h20, 6'h3F, 2'd3); do_txn(0, 1);
        set_req(1, 6'h20, 6'd1, 2'd1);  do_txn(0, 0);

        // Both continuously valid: alternation, then a long consumer stall
        v0 = 1'b1; v1 = 1'b1;
        a0 = 6'd3; b0 = 6'd4; op0 = 2'd0;
        a1 = 6'd10; b1 = 6'h3E; op1 = 2'd1;
        for (int i = 0; i < 6; i++) do_txn(1, (i == 2) ? 5 : 0);
        v0 = 1'b0; v1 = 1'b0;

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            v0 = r[0]; v1 = r[1];
            a0 = 6'($urandom); b0 = 6'($urandom); op0 = 2'($urandom_range(0, 3));
            a1 = 6'($urandom); b1 = 6'($urandom); op1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin b0 = '0; b1 = '0; end
            do_txn(0, $urandom_range(0, 3));
        end

        // Reset mid-EXEC of a div granted to req0 (pointer now favours req1)
        set_req(0, 6'h33, 6'd4, 2'd3);
        @(negedge clk);
        chk("rst_pre_grant0", ready0, 1);
        @(posedge clk); #1;
        chk("rst_pre_busy", busy, 1);
        v0 = 1'b1; v1 = 1'b1;
        a0 = 6'd7; b0 = 6'd2; op0 = 2'd1;
        a1 = 6'd1; b1 = 6'd1; op1 = 2'd0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        ptr = 1'b0;
        do_txn(1, 0);
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter MUL_LAT, default 2, mult execute cycles (1..15).
REQ-002 Parameter DIV_LAT, default 4, div execute cycles (1..15).
REQ-003 clk_i  input  1  single clock, rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid_i / req1_valid_i  input  1 each  requester has an op pending.
REQ-006 req0_ready_o / req1_ready_o  output  1 each  op accepted this cycle.
REQ-007 req0_A_i, req0_B_i, req1_A_i, req1_B_i  input  6 each  signed operands.
REQ-008 req0_Op_i, req1_Op_i  input  2 each  00 add, 01 sub, 10 mult, 11 div.
REQ-009 rsp_valid_o  output  1  result held.
REQ-010 rsp_ready_i  input  1  consumer takes result.
REQ-011 rsp_data_o  output  12  result.
REQ-012 rsp_id_o  output  1  requester that issued the op.
REQ-013 rsp_err_o  output  1  divide-by-zero or unsupported op.
REQ-014 busy_o  output  1  state != IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, RESP.
- IDLE -> EXEC on a grant.
- EXEC -> RESP when the latency counter expires.
- RESP -> IDLE on rsp_ready_i.
REQ-016 Grants occur only in IDLE.
- Both requesters valid: round-robin, requester 0 first after reset; priority flips to the other requester after each grant.
- Exactly one ready_o pulses for 1 cycle, in the cycle of the grant.
- Operands, op and id are captured at the grant edge.
REQ-017 EXEC latency: add/sub 1 cycle; mult MUL_LAT; div DIV_LAT. A 4-bit down-counter loaded at grant.
REQ-018 Result formats (12-bit sign-extended arithmetic):
- add/sub: {6'b0, sum[5:0]}, overflow discarded.
- mult: full 12-bit signed product.
- div: {rem[5:0], quot[5:0]}, truncation toward zero, remainder takes the sign of the dividend.
REQ-019 Div with B=0: rsp_data_o=12'hFFF, rsp_err_o=1; latency is unchanged.
REQ-020 In RESP, rsp_valid_o=1 and rsp_data_o/rsp_id_o/rsp_err_o stay stable until the cycle rsp_ready_i=1; that cycle is the handshake.
REQ-021 After the RESP handshake, the next grant occurs no earlier than the following cycle; minimum issue interval is 3 cycles for add/sub.
REQ-022 Requester valid_i deasserting before its grant is legal; the request is dropped without side effect.

Reset
REQ-023 rst_n_i low asynchronously forces the following, including mid-EXEC or mid-RESP:
- state=IDLE, counter=0, round-robin pointer=0.
- rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0, ready_o=0, busy_o=0.
- Any in-flight op is lost.
REQ-024 Reset deassertion is synchronised externally; the first grant may occur in the first cycle after release.

Configuration
REQ-025 With macro ALU_ARB_DIV_EN defined, div executes per REQ-017..019.
REQ-026 Without ALU_ARB_DIV_EN:
- No divider logic is present.
- Op 11 is still granted, with 1-cycle EXEC, rsp_data_o=12'h000 and rsp_err_o=1.

Structure
REQ-027 Shared package alu_pkg holds:
- op encoding constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
- FSM state typedef;
- width constant DW=6 and result width RW=12.
REQ-028 Sub-module alu_core: purely combinational; computes REQ-018/019 results and the err flag from registered operands; owns the ALU_ARB_DIV_EN guard.

Verification
REQ-029 Single add, req0 A=5, B=-3 (6'h3D), rsp_ready_i=1:
- ready0 in cycle 0; rsp_valid_o in cycle 2.
- data=12'h002, id=0, err=0.
REQ-030 Mult, req1 A=-7, B=9, MUL_LAT=2:
- rsp_valid_o 3 cycles after grant, data=12'hFC1 (-63), id=1.
REQ-031 Div, A=-13, B=4 (ALU_ARB_DIV_EN):
- quot=-3, rem=-1, data={6'h3F, 6'h3D}=12'hFFD.
- With B=0: data=12'hFFF, err=1.
REQ-032 Both requesters continuously valid with add ops: grants alternate 0,1,0,1; results in order; ids match.
REQ-033 rsp_ready_i held 0 for 5 cycles in RESP: outputs stable, no new grant, both ready_o=0; ready_i=1 releases.
REQ-034 rst_n_i asserted mid-EXEC of a div: all outputs 0 immediately; after release, req1 then req0 pending -> req0 granted first.
